// File: rtl/sp_subcarrier_demap.sv
`default_nettype none
// ============================================================================
// Module   : sp_subcarrier_demap
// Purpose  : Reorders 64-bin FFT symbols into logical subcarriers -26..+26,
//            drops DC/guards, splits pilots, streams tagged data subcarriers.
// Revision : 1.0 - initial release
// ============================================================================
module sp_subcarrier_demap #(
    parameter int MAX_SYM = 7,
    parameter int DW      = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof,
    input  logic [DW-1:0] di_re,
    input  logic [DW-1:0] di_im,
    input  logic          di_vld,
    output logic [DW-1:0] do_re,
    output logic [DW-1:0] do_im,
    output logic [5:0]    do_idx,
    output logic [2:0]    do_sym,
    output logic          do_vld,
    output logic [DW-1:0] pl_re,
    output logic [DW-1:0] pl_im,
    output logic [1:0]    pl_idx,
    output logic          pl_vld,
    output logic          sym_done
);

    localparam logic [5:0] c_last_bin  = 6'd63;
    localparam logic [5:0] c_last_rcnt = 6'd51;
    localparam logic [5:0] c_split     = 6'd26;
    localparam logic [5:0] c_neg_base  = 6'd38;
    localparam logic [5:0] c_pos_off   = 6'd25;
    localparam logic [5:0] c_last_didx = 6'd47;
    localparam logic [2:0] c_last_sym  = 3'(MAX_SYM - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_READ = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [2*DW-1:0] r_mem [0:127];
    logic [2*DW-1:0] r_s1_data;

    logic            r_wb;
    logic [5:0]      r_wcnt;
    logic [1:0]      r_full;
    logic            r_rb;
    logic [5:0]      r_rcnt;
    logic [5:0]      r_didx;
    logic [2:0]      r_sym;

    logic            r_s1_dvld;
    logic            r_s1_pvld;
    logic [5:0]      r_s1_didx;
    logic [1:0]      r_s1_pidx;
    logic [2:0]      r_s1_sym;
    logic            r_s1_last;

    logic [5:0]      w_bin;
    logic            w_rd_active;
    logic            w_rd_end;
    logic            w_is_pilot;
    logic [1:0]      w_pl_idx;
    logic [6:0]      w_wr_addr;
    logic [6:0]      w_rd_addr;

    assign w_rd_active = (r_state == S_READ);
    assign w_rd_end    = w_rd_active && (r_rcnt == c_last_rcnt);

    // Logical -26..-1 live in bins 38..63, +1..+26 in bins 1..26.
    assign w_bin     = (r_rcnt < c_split) ? (r_rcnt + c_neg_base) : (r_rcnt - c_pos_off);
    assign w_rd_addr = {r_rb, w_bin};
    // A write coinciding with sof always lands at bank 0, bin 0.
    assign w_wr_addr = sof ? 7'd0 : {r_wb, r_wcnt};

    always_comb begin
        w_is_pilot = 1'b0;
        w_pl_idx   = 2'd0;
        case (w_bin)
            6'd43: begin w_is_pilot = 1'b1; w_pl_idx = 2'd0; end
            6'd57: begin w_is_pilot = 1'b1; w_pl_idx = 2'd1; end
            6'd7:  begin w_is_pilot = 1'b1; w_pl_idx = 2'd2; end
            6'd21: begin w_is_pilot = 1'b1; w_pl_idx = 2'd3; end
            default: begin
                w_is_pilot = 1'b0;
                w_pl_idx   = 2'd0;
            end
        endcase
    end

    // Ping-pong storage; bank under write never collides with the bank under read.
    always_ff @(posedge clk) begin
        if (di_vld) begin
            r_mem[w_wr_addr] <= {di_re, di_im};
        end
        r_s1_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb   <= 1'b0;
            r_wcnt <= 6'd0;
            r_full <= 2'b00;
        end else if (sof) begin
            r_wb   <= 1'b0;
            r_full <= 2'b00;
            r_wcnt <= di_vld ? 6'd1 : 6'd0;
        end else begin
            if (w_rd_end) begin
                r_full[r_rb] <= 1'b0;
            end
            if (di_vld) begin
                r_wcnt <= r_wcnt + 6'd1;
                if (r_wcnt == c_last_bin) begin
                    r_full[r_wb] <= 1'b1;
                    r_wb         <= ~r_wb;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (r_full[r_rb]) w_state_nxt = S_READ;
            S_READ: if (w_rd_end)     w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
        if (sof) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt <= 6'd0;
            r_didx <= 6'd0;
            r_rb   <= 1'b0;
            r_sym  <= 3'd0;
        end else if (sof) begin
            r_rcnt <= 6'd0;
            r_didx <= 6'd0;
            r_rb   <= 1'b0;
            r_sym  <= 3'd0;
        end else if (w_rd_active) begin
            r_rcnt <= r_rcnt + 6'd1;
            if (!w_is_pilot) begin
                r_didx <= r_didx + 6'd1;
            end
            if (w_rd_end) begin
                r_rcnt <= 6'd0;
                r_didx <= 6'd0;
                r_rb   <= ~r_rb;
                r_sym  <= (r_sym == c_last_sym) ? 3'd0 : r_sym + 3'd1;
            end
        end else begin
            r_rcnt <= 6'd0;
            r_didx <= 6'd0;
        end
    end

    // Tags travel alongside the synchronous RAM read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_dvld <= 1'b0;
            r_s1_pvld <= 1'b0;
            r_s1_didx <= 6'd0;
            r_s1_pidx <= 2'd0;
            r_s1_sym  <= 3'd0;
            r_s1_last <= 1'b0;
        end else begin
            r_s1_dvld <= w_rd_active && !w_is_pilot && !sof;
            r_s1_pvld <= w_rd_active &&  w_is_pilot && !sof;
            r_s1_didx <= r_didx;
            r_s1_pidx <= w_pl_idx;
            r_s1_sym  <= r_sym;
            r_s1_last <= (r_didx == c_last_didx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            do_re    <= '0;
            do_im    <= '0;
            do_idx   <= 6'd0;
            do_sym   <= 3'd0;
            do_vld   <= 1'b0;
            pl_re    <= '0;
            pl_im    <= '0;
            pl_idx   <= 2'd0;
            pl_vld   <= 1'b0;
            sym_done <= 1'b0;
        end else begin
            do_vld   <= r_s1_dvld && !sof;
            pl_vld   <= r_s1_pvld && !sof;
            sym_done <= r_s1_dvld && r_s1_last && !sof;
            if (r_s1_dvld) begin
                do_re  <= r_s1_data[2*DW-1:DW];
                do_im  <= r_s1_data[DW-1:0];
                do_idx <= r_s1_didx;
                do_sym <= r_s1_sym;
            end
            if (r_s1_pvld) begin
                pl_re  <= r_s1_data[2*DW-1:DW];
                pl_im  <= r_s1_data[DW-1:0];
                pl_idx <= r_s1_pidx;
            end
        end
    end

endmodule
`default_nettype wire
